// File: rtl/spi_slave_gen.sv
// SPI slave frame engine: receives {cmd[1:0], payload} frames on MOSI,
// tracks a pending read address and returns memory read data on MISO.
// The first wire bit of a frame selects write (0) or read (1); with LSB_FIRST
// the received bits fill rx_data from bit 0 upward, otherwise from the top.
module spi_slave_gen #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              rd_pending,
    output logic              frame_err
);

    localparam int unsigned FW = DATA_W + 2;
    localparam int unsigned CW = $clog2(FW);

    typedef enum logic [2:0] {
        StIdle, StChkCmd, StWrite, StReadAdd, StReadData, StTxWait, StTxShift, StDone
    } state_t;

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [FW-1:0]   rx_shreg;
    logic [DATA_W-1:0] tx_shreg;

    logic [FW-1:0]   rx_first;
    logic [FW-1:0]   rx_next;
    logic            tx_first_bit;
    logic [DATA_W-1:0] tx_after_first;
    logic            tx_cur_bit;
    logic [DATA_W-1:0] tx_after_cur;
    logic            abort;

    // Bit-order dependent shift values for receive and transmit paths
    always_comb begin
        rx_first       = '0;
        rx_next        = '0;
        tx_first_bit   = 1'b0;
        tx_after_first = '0;
        tx_cur_bit     = 1'b0;
        tx_after_cur   = '0;
        if (LSB_FIRST) begin
            rx_first       = {MOSI, {(FW-1){1'b0}}};
            rx_next        = {MOSI, rx_shreg[FW-1:1]};
            tx_first_bit   = tx_data[0];
            tx_after_first = tx_data >> 1;
            tx_cur_bit     = tx_shreg[0];
            tx_after_cur   = tx_shreg >> 1;
        end else begin
            rx_first       = {{(FW-1){1'b0}}, MOSI};
            rx_next        = {rx_shreg[FW-2:0], MOSI};
            tx_first_bit   = tx_data[DATA_W-1];
            tx_after_first = tx_data << 1;
            tx_cur_bit     = tx_shreg[DATA_W-1];
            tx_after_cur   = tx_shreg << 1;
        end
    end

    // SS_n rising while a frame or transmit is in flight aborts it
    always_comb begin
        abort = SS_n && (state inside {StChkCmd, StWrite, StReadAdd, StReadData,
                                       StTxWait, StTxShift});
    end

    // Frame FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            bit_cnt    <= '0;
            rx_shreg   <= '0;
            tx_shreg   <= '0;
            MISO       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rd_pending <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (abort) begin
                // Partial frame is dropped; rd_pending is deliberately kept
                state     <= StIdle;
                frame_err <= 1'b1;
                bit_cnt   <= '0;
                rx_shreg  <= '0;
                tx_shreg  <= '0;
                MISO      <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        MISO <= 1'b0;
                        if (!SS_n) begin
                            state    <= StChkCmd;
                            bit_cnt  <= '0;
                            rx_shreg <= '0;
                        end
                    end
                    StChkCmd: begin
                        rx_shreg <= rx_first;
                        bit_cnt  <= CW'(FW - 2);
                        if (!MOSI) begin
                            state <= StWrite;
                        end else if (rd_pending) begin
                            state <= StReadData;
                        end else begin
                            state <= StReadAdd;
                        end
                    end
                    StWrite, StReadAdd, StReadData: begin
                        rx_shreg <= rx_next;
                        if (bit_cnt == '0) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            if (state == StReadData) begin
                                state <= StTxWait;
                            end else begin
                                state <= StDone;
                            end
                            if (state == StReadAdd) begin
                                rd_pending <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt - CW'(1);
                        end
                    end
                    StTxWait: begin
                        MISO <= 1'b0;
                        if (tx_valid) begin
                            MISO     <= tx_first_bit;
                            tx_shreg <= tx_after_first;
                            bit_cnt  <= CW'(DATA_W - 1);
                            state    <= StTxShift;
                        end
                    end
                    StTxShift: begin
                        if (bit_cnt == '0) begin
                            // Last bit has been on MISO for a full cycle
                            MISO       <= 1'b0;
                            rd_pending <= 1'b0;
                            state      <= StDone;
                        end else begin
                            MISO     <= tx_cur_bit;
                            tx_shreg <= tx_after_cur;
                            bit_cnt  <= bit_cnt - CW'(1);
                        end
                    end
                    StDone: begin
                        MISO <= 1'b0;
                        if (SS_n) begin
                            state <= StIdle;
                        end
                    end
                    default: begin
                        state <= StIdle;
                        MISO  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen: an MSB-first and an LSB-first instance share the
// same wire stimulus; a frame-level model predicts rx_data, rd_pending and MISO.
module tb_spi_slave_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic       miso_m, miso_l, rxv_m, rxv_l, pend_m, pend_l, ferr_m, ferr_l;
    logic [9:0] rxd_m, rxd_l;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0;
    bit pend = 1'b0;

    spi_slave_gen #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso_m),
        .rx_data(rxd_m), .rx_valid(rxv_m), .tx_data(tx_data), .tx_valid(tx_valid),
        .rd_pending(pend_m), .frame_err(ferr_m)
    );

    spi_slave_gen #(.DATA_W(8), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .MOSI(mosi), .MISO(miso_l),
        .rx_data(rxd_l), .rx_valid(rxv_l), .tx_data(tx_data), .tx_valid(tx_valid),
        .rd_pending(pend_l), .frame_err(ferr_l)
    );

    always #5 clk = ~clk;

    // Count rx_valid cycles of both instances
    always @(negedge clk) begin
        rxv_cnt += int'(rxv_m) + int'(rxv_l);
    end

    function automatic logic [9:0] rev10(input logic [9:0] f);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = f[9-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One master transaction; f is sent first bit = f[9] on the wire.
    task automatic do_frame(input logic [9:0] f, input int abort_at, input int stall,
                            input logic [7:0] txd, input bit tx_abort);
        int rv0;
        logic [9:0] fr;
        rv0 = rxv_cnt;
        fr  = rev10(f);
        ss_n = 1'b0; mosi = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i == abort_at) begin
                ss_n = 1'b1;
                tick();
                checks++;
                if (ferr_m !== 1'b1 || ferr_l !== 1'b1) begin
                    errors++; $display("FAIL abort_ferr got %b/%b want 1", ferr_m, ferr_l);
                end
                checks++;
                if (rxv_m !== 1'b0 || rxv_l !== 1'b0 || pend_m !== pend || pend_l !== pend) begin
                    errors++;
                    $display("FAIL abort_state rxv %b/%b pend %b/%b want rxv 0 pend %b",
                             rxv_m, rxv_l, pend_m, pend_l, pend);
                end
                tick();
                checks++;
                if (ferr_m !== 1'b0 || ferr_l !== 1'b0 || rxv_cnt != rv0) begin
                    errors++;
                    $display("FAIL abort_pulse ferr %b/%b rxv_cnt %0d want 0 and %0d",
                             ferr_m, ferr_l, rxv_cnt, rv0);
                end
                return;
            end
            mosi = f[9-i];
            tick();
            checks++;
            if (miso_m !== 1'b0 || miso_l !== 1'b0) begin
                errors++; $display("FAIL miso_rx got %b/%b want 0", miso_m, miso_l);
            end
        end
        checks++;
        if (rxv_m !== 1'b1 || rxv_l !== 1'b1 || rxv_cnt != rv0) begin
            errors++;
            $display("FAIL rx_valid_timing got %b/%b early %0d want 1/1 early 0",
                     rxv_m, rxv_l, rxv_cnt - rv0);
        end
        checks++;
        if (rxd_m !== f || rxd_l !== fr) begin
            errors++;
            $display("FAIL rx_data got %h/%h want %h/%h", rxd_m, rxd_l, f, fr);
        end
        mosi = 1'($urandom_range(1, 0));
        if (f[9] && pend) begin
            for (int s = 0; s < stall; s++) begin
                tick();
                checks++;
                if (miso_m !== 1'b0 || miso_l !== 1'b0 || rxv_m !== 1'b0 || pend_m !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_stall miso %b/%b rxv %b pend %b want 0/0 0 1",
                             miso_m, miso_l, rxv_m, pend_m);
                end
            end
            if (tx_abort) begin
                ss_n = 1'b1;
                tick();
                checks++;
                if (ferr_m !== 1'b1 || ferr_l !== 1'b1 || pend_m !== 1'b1 || pend_l !== 1'b1
                    || miso_m !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_abort ferr %b/%b pend %b/%b miso %b want 1/1 1/1 0",
                             ferr_m, ferr_l, pend_m, pend_l, miso_m);
                end
                tick();
                return;
            end
            tx_valid = 1'b1; tx_data = txd;
            tick();
            tx_valid = 1'b0; tx_data = 8'($urandom);
            for (int k = 0; k < 8; k++) begin
                if (k > 0) tick();
                checks++;
                if (miso_m !== txd[7-k] || miso_l !== txd[k] || pend_m !== 1'b1) begin
                    errors++;
                    $display("FAIL miso_bit%0d got %b/%b pend %b want %b/%b pend 1",
                             k, miso_m, miso_l, pend_m, txd[7-k], txd[k]);
                end
            end
            tick();
            pend = 1'b0;
            checks++;
            if (miso_m !== 1'b0 || miso_l !== 1'b0 || pend_m !== 1'b0 || pend_l !== 1'b0) begin
                errors++;
                $display("FAIL tx_end miso %b/%b pend %b/%b want 0", miso_m, miso_l, pend_m, pend_l);
            end
        end else begin
            if (f[9]) pend = 1'b1;
            tick();
            checks++;
            if (rxv_m !== 1'b0 || rxv_l !== 1'b0 || pend_m !== pend || pend_l !== pend) begin
                errors++;
                $display("FAIL post_frame rxv %b/%b pend %b/%b want 0 pend %b",
                         rxv_m, rxv_l, pend_m, pend_l, pend);
            end
        end
        ss_n = 1'b1;
        tick();
        tick();
        checks++;
        if (rxv_cnt != rv0 + 2 || rxd_m !== f || rxd_l !== fr) begin
            errors++;
            $display("FAIL rx_hold pulses %0d data %h/%h want 2 %h/%h",
                     rxv_cnt - rv0, rxd_m, rxd_l, f, fr);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        tick(); tick();
        checks++;
        if (miso_m !== 1'b0 || rxv_m !== 1'b0 || rxd_m !== 10'h0 || pend_m !== 1'b0
            || ferr_m !== 1'b0 || miso_l !== 1'b0 || rxd_l !== 10'h0 || pend_l !== 1'b0) begin
            errors++;
            $display("FAIL reset miso %b rxv %b rxd %h/%h pend %b ferr %b want all 0",
                     miso_m, rxv_m, rxd_m, rxd_l, pend_m, ferr_m);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        pend = 1'b0;
    endtask

    task automatic test_write();
        do_frame(10'h0A5, -1, 0, 8'h00, 1'b0);
    endtask

    task automatic test_read_pair();
        do_frame(10'h23C, -1, 0, 8'h00, 1'b0);
        do_frame(10'h300 | 10'($urandom_range(255, 0)), -1, 0, 8'h96, 1'b0);
    endtask

    task automatic test_abort();
        do_frame(10'h0A5, 5, 0, 8'h00, 1'b0);
        do_frame(10'h0A5, -1, 0, 8'h00, 1'b0);
    endtask

    task automatic test_stall();
        do_frame(10'h2C3, -1, 0, 8'h00, 1'b0);
        do_frame(10'h35A, -1, 20, 8'h96, 1'b0);
        do_frame(10'h211, -1, 0, 8'h00, 1'b0);
        do_frame(10'h3E7, -1, 5, 8'h96, 1'b1);
        do_frame(10'h3A0, -1, 0, 8'h5C, 1'b0);
    endtask

    task automatic test_lsb();
        do_frame(10'h294, -1, 0, 8'h00, 1'b0);
        checks++;
        if (rxd_l !== 10'h0A5) begin
            errors++; $display("FAIL lsb_rx_data got %h want 0a5", rxd_l);
        end
        do_frame(10'h300, -1, 0, 8'h96, 1'b0);
    endtask

    task automatic test_reset_mid_tx();
        if (!pend) do_frame(10'h2F0, -1, 0, 8'h00, 1'b0);
        ss_n = 1'b0; mosi = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            mosi = (i < 2) ? 1'b1 : 1'b0;
            tick();
        end
        tx_valid = 1'b1; tx_data = 8'h96;
        tick();
        tx_valid = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        pend = 1'b0;
        checks++;
        if (miso_m !== 1'b0 || miso_l !== 1'b0 || pend_m !== 1'b0 || pend_l !== 1'b0
            || rxd_m !== 10'h0 || rxv_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_tx miso %b/%b pend %b/%b rxd %h want 0",
                     miso_m, miso_l, pend_m, pend_l, rxd_m);
        end
        ss_n = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tick();
        do_frame(10'h2AB, -1, 0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int ab;
            ab = ($urandom_range(7, 0) == 0) ? int'($urandom_range(9, 0)) : -1;
            do_frame(10'($urandom), ab, int'($urandom_range(3, 0)), 8'($urandom),
                     ($urandom_range(9, 0) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_pair();
        test_abort();
        test_stall();
        test_lsb();
        test_reset_mid_tx();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_gen.md
SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits; frame width FW = DATA_W+2.
REQ-002 Parameter LSB_FIRST, default 0: 0 = MSB-first on MOSI and MISO, 1 = LSB-first on both.
REQ-003 clk  input  1  system clock; MOSI, SS_n and tx_valid are sampled on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SS_n  input  1  slave select, active-low; low = frame in progress.
REQ-006 MOSI  input  1  serial data from master.
REQ-007 MISO  output  1  serial read data to master, registered.
REQ-008 rx_data  output  FW  received frame {cmd[1:0], payload[DATA_W-1:0]}.
REQ-009 rx_valid  output  1  one-cycle pulse; rx_data is valid while it is high.
REQ-010 tx_data  input  DATA_W  read data returned by the memory.
REQ-011 tx_valid  input  1  tx_data is valid; sampled only in TX_WAIT.
REQ-012 rd_pending  output  1  a read address has been accepted and the read-data frame has not yet completed.
REQ-013 frame_err  output  1  one-cycle pulse on aborted frame or aborted transmit.

Function
REQ-014 States SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT and DONE, registered with a single current-state register.
REQ-015 IDLE SHALL move to CHK_CMD on an edge with SS_n=0, and otherwise stay in IDLE.
REQ-016 CHK_CMD SHALL sample MOSI as frame bit FW-1 (cmd[1]), with the following next state:
- MOSI=0: WRITE.
- MOSI=1 and rd_pending=0: READ_ADD.
- MOSI=1 and rd_pending=1: READ_DATA.
REQ-017 WRITE, READ_ADD and READ_DATA SHALL each shift in the remaining FW-1 bits, one per edge, using a down-counter.
REQ-018 On the edge that samples the last bit, the block SHALL:
- load rx_data with the full frame;
- assert rx_valid for exactly one cycle;
- transfer WRITE to DONE, READ_ADD to DONE, and READ_DATA to TX_WAIT.
REQ-019 The cmd field SHALL be forwarded exactly as received; the block SHALL NOT alter or check it.
REQ-020 rd_pending SHALL set on READ_ADD frame completion and SHALL clear when TX_SHIFT finishes its last bit.
REQ-021 TX_WAIT SHALL hold until an edge with tx_valid=1; on that edge the block SHALL capture tx_data, drive its first bit on MISO, and enter TX_SHIFT.
REQ-022 TX_SHIFT SHALL present one further bit per edge, giving DATA_W bits in total on MISO, then enter DONE.
REQ-023 MISO SHALL be 0 in every state other than TX_SHIFT.
REQ-024 DONE SHALL ignore MOSI and return to IDLE on an edge with SS_n=1.
REQ-025 SS_n=1 sampled in CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT or TX_SHIFT SHALL cause, on that edge:
- return to IDLE;
- discard the partial frame with no rx_valid;
- a frame_err pulse;
- reset of the bit counter;
- rd_pending unchanged.
REQ-026 A new frame SHALL always restart the bit count from zero, with no state carried over from an aborted frame except rd_pending.
REQ-027 rx_data SHALL hold its last value between frames.
REQ-028 Latency: rx_valid SHALL be high in the cycle after the FW+1-th edge counted from the first edge with SS_n=0.

Reset
REQ-029 rst_n=0 SHALL immediately force the following, regardless of state, including mid-frame and mid-transmit:
- state IDLE;
- MISO=0, rx_valid=0, rx_data=0;
- rd_pending=0, frame_err=0;
- bit counter and shift registers cleared.
REQ-030 After rst_n deasserts, the first frame SHALL be decoded as if no previous read address had been sent.

Verification (DATA_W=8, LSB_FIRST=0 unless stated)
REQ-031 Write frame: SS_n low, MOSI shifts 0,0,1,0,1,0,0,1,0,1 -> rx_data=10'h0A5, rx_valid high exactly one cycle after the 11th edge, then DONE, then IDLE on SS_n high.
REQ-032 Read pair:
- Stimulus: frame 10'h23C, SS_n high, then frame 10'h3xx; tx_valid=1 with tx_data=8'h96 in TX_WAIT.
- Response: rd_pending=1 after the first frame; MISO = 1,0,0,1,0,1,1,0 on 8 consecutive cycles; rd_pending=0 afterwards.
REQ-033 Abort: SS_n high after 5 bits of a write frame -> no rx_valid, one frame_err pulse, IDLE; the next full frame decodes correctly.
REQ-034 Reset mid-transmit: rst_n low during TX_SHIFT of 8'h96 -> MISO=0 and rd_pending=0 immediately; the next MOSI=1 frame enters READ_ADD.
REQ-035 LSB_FIRST=1: MOSI bits 1,0,1,0,0,1,0,1,0,0 -> rx_data=10'h0A5; tx_data=8'h96 -> MISO = 0,1,1,0,1,0,0,1.
REQ-036 tx_valid stall: tx_valid held low 20 cycles in TX_WAIT, then high -> MISO stays 0 during the stall, then transmits correctly; an SS_n rise during the stall gives frame_err with rd_pending still 1.
